// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 1024x768@60 (65 MHz) VGA scan timing generator.
// Produces the pixel/line counters, the blanking and sync strobes, and the
// line/frame markers. Scan-out always starts at (0,0). It stops only after the
// last pixel of a frame.
// Ports:
//   clk, rst       pixel clock, asynchronous active-high reset
//   en             run request (level)
//   running        counters advancing (RUN or STOPPING)
//   hcount/vcount  current pixel column / line
//   hblnk/vblnk    blanking, active-high
//   hsync/vsync    sync strobes at SYNC_ACTIVE level
//   line_start     pulse at hcount==0 while running
//   frame_start    pulse at (0,0) while running
//   frame_cnt      completed frames since reset, wrapping
module vga_timing_ctrl #(
   parameter int unsigned HOR_TOTAL    = 1344,
   parameter int unsigned HBLANK_START = 1024,
   parameter int unsigned HSYNC_START  = 1048,
   parameter int unsigned HSYNC_STOP   = 1184,
   parameter int unsigned VER_TOTAL    = 806,
   parameter int unsigned VBLANK_START = 768,
   parameter int unsigned VSYNC_START  = 771,
   parameter int unsigned VSYNC_STOP   = 777,
   parameter logic        SYNC_ACTIVE  = 1'b0,
   parameter int unsigned FCNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              running,
   output logic [10:0]       hcount,
   output logic [10:0]       vcount,
   output logic              hblnk,
   output logic              vblnk,
   output logic              hsync,
   output logic              vsync,
   output logic              line_start,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int unsigned CNT_W = 11;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HOR_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VER_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_BLNK_S = CNT_W'(HBLANK_START);
   localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(HSYNC_START);
   localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(HSYNC_STOP);
   localparam logic [CNT_W-1:0] V_BLNK_S = CNT_W'(VBLANK_START);
   localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(VSYNC_START);
   localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(VSYNC_STOP);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic              running_q, running_d;
   logic [CNT_W-1:0]  hcount_q, hcount_d;
   logic [CNT_W-1:0]  vcount_q, vcount_d;
   logic              hblnk_q, hblnk_d;
   logic              vblnk_q, vblnk_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              line_start_q, line_start_d;
   logic              frame_start_q, frame_start_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic              at_end_c;

   // Last pixel of the last line is currently on the outputs.
   assign at_end_c = running_q && (hcount_q == H_LAST) && (vcount_q == V_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a stop request is honoured only at the frame end.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (en) state_d = RUN;
         RUN:      if (!en) state_d = STOPPING;
         STOPPING: begin
            if (en) begin
               state_d = RUN;
            end else if (at_end_c) begin
               state_d = IDLE;
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   // Output/counter next values, decoded from the next counter values so the
   // strobes line up with hcount/vcount on the same cycle.
   always_comb begin
      // The first cycle after IDLE->RUN has running_q=0, so it shows (0,0).
      running_d   = (state_q != IDLE) && (state_d != IDLE);
      hcount_d    = '0;
      vcount_d    = '0;
      frame_cnt_d = frame_cnt_q;

      if (at_end_c) begin
         frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end

      if (running_d && running_q) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
            vcount_d = vcount_q;
         end
      end

      hblnk_d       = !running_d || (hcount_d >= H_BLNK_S);
      vblnk_d       = !running_d || (vcount_d >= V_BLNK_S);
      hsync_d       = (running_d && (hcount_d >= H_SYNC_S) && (hcount_d < H_SYNC_E))
                      ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = (running_d && (vcount_d >= V_SYNC_S) && (vcount_d < V_SYNC_E))
                      ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start_d  = running_d && (hcount_d == '0);
      frame_start_d = line_start_d && (vcount_d == '0);
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running_q     <= 1'b0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         hblnk_q       <= 1'b1;
         vblnk_q       <= 1'b1;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         running_q     <= running_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign running     = running_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hblnk       = hblnk_q;
   assign vblnk       = vblnk_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed bench for vga_timing_ctrl.
// dut_b runs the full 1024x768 mode for line-level checks. dut_s runs a
// scaled-down mode (20x10 totals, FCNT_W=2) so that multi-frame, stop and
// frame-counter behaviour fits in a short run.
module tb_vga_timing_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // full-size instance
   logic        rst_b, en_b;
   logic        b_running, b_hblnk, b_vblnk, b_hsync, b_vsync, b_line_start, b_frame_start;
   logic [10:0] b_hcount, b_vcount;
   logic [15:0] b_frame_cnt;
   logic [28:0] b_obs;
   assign b_obs = {b_running, b_hcount, b_vcount, b_hblnk, b_vblnk, b_hsync, b_vsync,
                   b_line_start, b_frame_start};

   vga_timing_ctrl dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .running(b_running),
      .hcount(b_hcount), .vcount(b_vcount), .hblnk(b_hblnk), .vblnk(b_vblnk),
      .hsync(b_hsync), .vsync(b_vsync), .line_start(b_line_start),
      .frame_start(b_frame_start), .frame_cnt(b_frame_cnt)
   );

   // scaled instance: frame = 20*10 = 200 clocks
   logic        rst_s, en_s;
   logic        s_running, s_hblnk, s_vblnk, s_hsync, s_vsync, s_line_start, s_frame_start;
   logic [10:0] s_hcount, s_vcount;
   logic [1:0]  s_frame_cnt;
   logic [30:0] s_obs;
   assign s_obs = {s_running, s_hcount, s_vcount, s_hblnk, s_vblnk, s_hsync, s_vsync,
                   s_line_start, s_frame_start, s_frame_cnt};

   vga_timing_ctrl #(
      .HOR_TOTAL(20), .HBLANK_START(12), .HSYNC_START(14), .HSYNC_STOP(17),
      .VER_TOTAL(10), .VBLANK_START(6), .VSYNC_START(7), .VSYNC_STOP(9),
      .SYNC_ACTIVE(1'b0), .FCNT_W(2)
   ) dut_s (
      .clk(clk), .rst(rst_s), .en(en_s), .running(s_running),
      .hcount(s_hcount), .vcount(s_vcount), .hblnk(s_hblnk), .vblnk(s_vblnk),
      .hsync(s_hsync), .vsync(s_vsync), .line_start(s_line_start),
      .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
   );

   localparam logic [28:0] B_IDLE  = {1'b0, 11'd0, 11'd0, 4'b1111, 2'b00};
   localparam logic [28:0] B_FIRST = {1'b1, 11'd0, 11'd0, 4'b0011, 2'b11};

   // Scaled-mode model: i = cycles since the first running cycle.
   function automatic logic [30:0] sm_exp(input int i, input int fc0);
      int h;
      int v;
      h = i % 20;
      v = (i / 20) % 10;
      return {1'b1, 11'(h), 11'(v), 1'(h >= 12), 1'(v >= 6),
              1'(!(h >= 14 && h < 17)), 1'(!(v >= 7 && v < 9)),
              1'(h == 0), 1'(h == 0 && v == 0), 2'(fc0 + i / 200)};
   endfunction

   function automatic logic [30:0] sm_idle(input int fc);
      return {1'b0, 11'd0, 11'd0, 4'b1111, 2'b00, 2'(fc)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, release en, advance to the first running cycle of dut_s.
   task automatic start_small();
      rst_s = 1'b1;
      en_s  = 1'b0;
      tick();
      rst_s = 1'b0;
      en_s  = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_b = 1'b1; en_b = 1'b0;
      rst_s = 1'b1; en_s = 1'b0;
      repeat (3) tick();
      rst_b = 1'b0;
      rst_s = 1'b0;
      tick();
      n_vec++;
      if (b_obs !== B_IDLE) begin
         n_err++;
         $display("FAIL reset_big_outputs: got %h want %h", b_obs, B_IDLE);
      end
      n_vec++;
      if (b_frame_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL reset_big_frame_cnt: got %0d want 0", b_frame_cnt);
      end
      n_vec++;
      if (s_obs !== sm_idle(0)) begin
         n_err++;
         $display("FAIL reset_small_outputs: got %h want %h", s_obs, sm_idle(0));
      end
   endtask

   task automatic test_start_latency();
      en_b = 1'b1;
      tick();
      n_vec++;
      if (b_obs !== B_IDLE) begin
         n_err++;
         $display("FAIL start_latency_edge1: got %h want %h", b_obs, B_IDLE);
      end
      tick();
      n_vec++;
      if (b_obs !== B_FIRST) begin
         n_err++;
         $display("FAIL start_first_cycle: got %h want %h", b_obs, B_FIRST);
      end
   endtask

   // Two full-size lines; boundary columns checked against hand-derived decode.
   task automatic test_line_decode();
      int h;
      int v;
      int hs_low;
      int hb_high;
      logic [28:0] exp;
      hs_low  = 0;
      hb_high = 0;
      for (int i = 1; i <= 2 * 1344 + 5; i++) begin
         tick();
         h = i % 1344;
         v = i / 1344;
         if (v == 1) begin
            if (b_hsync === 1'b0) hs_low++;
            if (b_hblnk === 1'b1) hb_high++;
         end
         if (h inside {0, 1, 1023, 1024, 1047, 1048, 1183, 1184, 1343}) begin
            exp = {1'b1, 11'(h), 11'(v), 1'(h >= 1024), 1'b0,
                   1'(!(h >= 1048 && h < 1184)), 1'b1, 1'(h == 0), 1'(h == 0 && v == 0)};
            n_vec++;
            if (b_obs !== exp) begin
               n_err++;
               $display("FAIL line_decode h=%0d v=%0d: got %h want %h", h, v, b_obs, exp);
            end
         end
      end
      n_vec++;
      if (hs_low !== 136) begin
         n_err++;
         $display("FAIL hsync_width: got %0d want 136", hs_low);
      end
      n_vec++;
      if (hb_high !== 320) begin
         n_err++;
         $display("FAIL hblnk_width: got %0d want 320", hb_high);
      end
   endtask

   // Continues from (5,2); reset lands between clock edges at (700,2).
   task automatic test_async_reset_big();
      repeat (695) tick();
      n_vec++;
      if (b_hcount !== 11'd700 || b_vcount !== 11'd2) begin
         n_err++;
         $display("FAIL pre_reset_position: got (%0d,%0d) want (700,2)", b_hcount, b_vcount);
      end
      #2;
      rst_b = 1'b1;
      #1;
      n_vec++;
      if (b_obs !== B_IDLE || b_frame_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL async_reset_big: got %h fc=%0d want %h fc=0", b_obs, b_frame_cnt, B_IDLE);
      end
      rst_b = 1'b0;
      tick();
      n_vec++;
      if (b_running !== 1'b0) begin
         n_err++;
         $display("FAIL restart_latency: running got %b want 0", b_running);
      end
      tick();
      n_vec++;
      if (b_obs !== B_FIRST) begin
         n_err++;
         $display("FAIL restart_first_cycle: got %h want %h", b_obs, B_FIRST);
      end
      rst_b = 1'b1;
      en_b  = 1'b0;
   endtask

   // Five scaled frames; frame_cnt must step 1,2,3,0,1 at each wrap.
   task automatic test_frames();
      logic [1:0] fc_seq [5];
      fc_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      start_small();
      for (int i = 0; i <= 1000; i++) begin
         if (i > 0) tick();
         n_vec++;
         if (s_obs !== sm_exp(i, 0)) begin
            n_err++;
            $display("FAIL frames i=%0d: got %h want %h", i, s_obs, sm_exp(i, 0));
         end
         if (i > 0 && i % 200 == 0) begin
            n_vec++;
            if (s_frame_cnt !== fc_seq[i / 200 - 1]) begin
               n_err++;
               $display("FAIL frame_cnt_seq wrap %0d: got %0d want %0d",
                        i / 200, s_frame_cnt, fc_seq[i / 200 - 1]);
            end
         end
      end
   endtask

   // en dropped at (5,3): finish the frame, go IDLE, hold frame_cnt.
   task automatic test_stop();
      start_small();
      for (int i = 0; i < 200; i++) begin
         if (i > 0) tick();
         n_vec++;
         if (s_obs !== sm_exp(i, 0)) begin
            n_err++;
            $display("FAIL stop_count i=%0d: got %h want %h", i, s_obs, sm_exp(i, 0));
         end
         if (i == 65) en_s = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++;
         if (s_obs !== sm_idle(1)) begin
            n_err++;
            $display("FAIL stop_idle k=%0d: got %h want %h", k, s_obs, sm_idle(1));
         end
      end
      en_s = 1'b1;
      tick();
      n_vec++;
      if (s_obs !== sm_idle(1)) begin
         n_err++;
         $display("FAIL rerun_latency: got %h want %h", s_obs, sm_idle(1));
      end
      tick();
      n_vec++;
      if (s_obs !== sm_exp(0, 1)) begin
         n_err++;
         $display("FAIL rerun_first_cycle: got %h want %h", s_obs, sm_exp(0, 1));
      end
   endtask

   // en low at (2,1), high again at (5,8): no stop, no discontinuity.
   task automatic test_back_to_back();
      start_small();
      for (int i = 0; i <= 215; i++) begin
         if (i > 0) tick();
         n_vec++;
         if (s_obs !== sm_exp(i, 0)) begin
            n_err++;
            $display("FAIL en_glitch i=%0d: got %h want %h", i, s_obs, sm_exp(i, 0));
         end
         if (i == 22)  en_s = 1'b0;
         if (i == 165) en_s = 1'b1;
      end
   endtask

   // Reset between edges at (7,4) of the second frame clears frame_cnt.
   task automatic test_async_reset_small();
      start_small();
      repeat (287) tick();
      n_vec++;
      if (s_obs !== sm_exp(287, 0)) begin
         n_err++;
         $display("FAIL pre_reset_small: got %h want %h", s_obs, sm_exp(287, 0));
      end
      #2;
      rst_s = 1'b1;
      #1;
      n_vec++;
      if (s_obs !== sm_idle(0)) begin
         n_err++;
         $display("FAIL async_reset_small: got %h want %h", s_obs, sm_idle(0));
      end
      rst_s = 1'b0;
      en_s  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start_latency();
      test_line_decode();
      test_async_reset_big();
      test_frames();
      test_stop();
      test_back_to_back();
      test_async_reset_small();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Frame-synchronous VGA timing controller for the 1024x768 @ 60 Hz, 65 MHz display path. Generates horizontal/vertical counters, blanking and sync strobes, and frame/line markers consumed by every draw stage downstream. A run/stop handshake starts scan-out cleanly at pixel (0,0) and lets it stop only at a frame boundary, so the monitor never sees a truncated frame.

## Interface
- HOR_TOTAL, 1344: pixel clocks per line; HBLANK_STOP equals this value.
- VER_TOTAL, 806: lines per frame; VBLANK_STOP equals this value.
- HBLANK_START, 1024; HSYNC_START, 1048; HSYNC_STOP, 1184: horizontal region bounds, start inclusive, stop exclusive.
- VBLANK_START, 768; VSYNC_START, 771; VSYNC_STOP, 777: vertical region bounds, start inclusive, stop exclusive.
- SYNC_ACTIVE, 1'b0: asserted level of hsync/vsync (0 = active-low, the mode's standard polarity).
- FCNT_W, 16: frame counter width.
- clk, input, 1: pixel clock, 65 MHz.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: run request (level).
- running, output, 1: 1 while counters advance (states RUN, STOPPING).
- hcount, output, 11: current pixel column, 0..HOR_TOTAL-1.
- vcount, output, 11: current line, 0..VER_TOTAL-1.
- hblnk, vblnk, output, 1 each: blanking, active-high.
- hsync, vsync, output, 1 each: sync at SYNC_ACTIVE level.
- line_start, output, 1: 1-cycle pulse when hcount==0 while running.
- frame_start, output, 1: 1-cycle pulse when hcount==0 and vcount==0 while running.
- frame_cnt, output, FCNT_W: completed frames since reset, wraps.

## Operation
- All outputs registered. Decode from next-state counter values, so hblnk/hsync/vblnk/vsync/pulses align with hcount/vcount in the same cycle.
- States:
  - IDLE: counters 0, hblnk=vblnk=1, syncs inactive (!SYNC_ACTIVE), pulses 0, running=0.
  - RUN: hcount increments each cycle. At HOR_TOTAL-1 it wraps to 0 and vcount increments. At vcount VER_TOTAL-1 it wraps to 0.
  - STOPPING: counts exactly as in RUN.
- Transitions:
  - IDLE -> RUN when en=1. First running cycle shows (0,0) with frame_start=1 and line_start=1.
  - RUN -> STOPPING when en=0.
  - STOPPING -> RUN when en=1 again. No counter disturbance.
  - STOPPING -> IDLE on the cycle after (HOR_TOTAL-1, VER_TOTAL-1), i.e. in place of the wrap to (0,0). frame_start is not pulsed on that cycle.
- Region decode: hblnk = hcount in [HBLANK_START, HOR_TOTAL); hsync active = hcount in [HSYNC_START, HSYNC_STOP); vertical decode likewise on vcount.
- frame_cnt increments by 1 on every wrap from (HOR_TOTAL-1, VER_TOTAL-1), including the final frame before IDLE. It wraps modulo 2^FCNT_W and is held, not cleared, in IDLE.
- Reset: IDLE, frame_cnt=0, all outputs at IDLE values. Reset mid-frame aborts immediately; this is the only way a frame is truncated.

## Timing
- en to first counting cycle: 2 clocks (en sampled at edge N, state RUN at N, outputs show (0,0) after edge N+1).
- en deassert takes effect only at the end of the current frame. Latency is 0 to HOR_TOTAL*VER_TOTAL-1 cycles.
- Line period is 1344 clocks. Frame period is 1,083,264 clocks (≈60.0 Hz at 65 MHz).
- hsync width is 136 clocks. vsync width is 6 lines (8064 clocks), starting at hcount==0 of line 771.
- hblnk high 320 clocks per line. vblnk high 38 lines.

## Test plan
- Reset then en=1: first running cycle hcount=0, vcount=0, frame_start=1, hblnk=0, hsync=1. After 1024 further cycles, hblnk=1.
- Continuous run for 2 frames: hsync low exactly for hcount 1048..1183; vsync low exactly for vcount 771..776. frame_start period 1,083,264 clocks; frame_cnt=2 after 2 wraps.
- Deassert en at (500,300): counting continues to (1343,805), then IDLE with hcount=vcount=0, hblnk=vblnk=1, running=0, frame_cnt incremented once.
- Deassert en at (10,10) and reassert at (20,400): no stop, no counter discontinuity, running stays 1.
- Assert rst at (700,500): all outputs at IDLE values asynchronously (before next clk edge), frame_cnt=0.
- Set FCNT_W=2 and run 5 frames: frame_cnt sequence 1,2,3,0,1.
